phase_controller: RTL and testbench



---
 rtl/phase_controller_pkg.sv | 27 ++
 rtl/phase_controller_if.sv | 30 +++
 rtl/phase_controller_edge_detect.sv | 23 ++
 rtl/phase_controller.sv | 150 +++++++++++++++
 tb/tb_phase_controller.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/phase_controller_pkg.sv
// rtl/phase_controller_pkg.sv - shared encodings and constants for the phase sequencer
package phase_controller_pkg;

    // Controller states; encodings are fixed so the datapath debug tap can decode them.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam int NUM_PHASES     = 5;
    localparam int ICNT_W_DEFAULT = 16;

    // Named phase indices of one SIMPLE instruction.
    localparam logic [2:0] P1 = 3'd0;
    localparam logic [2:0] P2 = 3'd1;
    localparam logic [2:0] P3 = 3'd2;
    localparam logic [2:0] P4 = 3'd3;
    localparam logic [2:0] P5 = 3'd4;

    // True in the states that clock the datapath.
    function automatic logic is_active(state_t s);
        return (s == RUN) || (s == STEP);
    endfunction

endpackage

// File: rtl/phase_controller_if.sv
// rtl/phase_controller_if.sv - control/status bundle between sequencer and datapath
interface phase_controller_if #(
    parameter int NUM_PHASES = phase_controller_pkg::NUM_PHASES,
    parameter int ICNT_W     = phase_controller_pkg::ICNT_W_DEFAULT
);
    import phase_controller_pkg::*;

    logic                  exec;
    logic                  step;
    logic                  halt;
    logic [2:0]            phase;
    logic [NUM_PHASES-1:0] phase_bus;
    logic                  reset_ps;
    logic                  running;
    logic                  halted;
    logic [ICNT_W-1:0]     instr_count;

    // The sequencer drives phases and status; buttons and HLT come in.
    modport master (
        input  exec, step, halt,
        output phase, phase_bus, reset_ps, running, halted, instr_count
    );

    // Datapath / front-panel side.
    modport slave (
        output exec, step, halt,
        input  phase, phase_bus, reset_ps, running, halted, instr_count
    );

endinterface

// File: rtl/phase_controller_edge_detect.sv
// rtl/phase_controller_edge_detect.sv - registered rising-edge detector for button levels
module phase_controller_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rise
);
    import phase_controller_pkg::*;

    logic din_q;

    // Previous-edge copy of the level; a held button produces only one rise.
    always_ff @(posedge clock) begin
        if (reset) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/phase_controller.sv
// rtl/phase_controller.sv - five-phase run/step/halt sequencer for the SIMPLE datapath
module phase_controller #(
    parameter int NUM_PHASES = phase_controller_pkg::NUM_PHASES,
    parameter int ICNT_W     = phase_controller_pkg::ICNT_W_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    phase_controller_if.master bus
);
    import phase_controller_pkg::*;

    localparam logic [2:0]            LAST_PHASE = 3'(NUM_PHASES - 1);
    localparam logic [NUM_PHASES-1:0] BUS_FIRST  = {{(NUM_PHASES-1){1'b0}}, 1'b1};
    localparam logic [ICNT_W-1:0]     ICNT_ONE   = {{(ICNT_W-1){1'b0}}, 1'b1};

    state_t                state_q, state_n;
    logic [2:0]            phase_q, phase_n;
    logic [NUM_PHASES-1:0] bus_q, bus_n;
    logic                  stop_q, stop_n;
    logic [ICNT_W-1:0]     icnt_q, icnt_n;
    logic                  running_q;
    logic                  halted_q;
    logic                  reset_ps_q;
    logic                  exec_rise;
    logic                  step_rise;
    logic                  at_boundary;
    logic                  stop_now;

    phase_controller_edge_detect u_exec_edge (
        .clock (clock),
        .reset (reset),
        .din   (bus.exec),
        .rise  (exec_rise)
    );

    phase_controller_edge_detect u_step_edge (
        .clock (clock),
        .reset (reset),
        .din   (bus.step),
        .rise  (step_rise)
    );

    // Last phase of the current instruction: the only point where we may stop or halt.
    assign at_boundary = (phase_q == LAST_PHASE);
    // A stop requested earlier, or one that lands on the boundary edge itself.
    assign stop_now    = stop_q || ((state_q == RUN) && exec_rise);

    // Datapath reset trails the controller reset by one edge.
    always_ff @(posedge clock) begin
        reset_ps_q <= reset;
    end

    // State, phase and counter registers; status flags follow the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= P1;
            bus_q     <= '0;
            stop_q    <= 1'b0;
            icnt_q    <= '0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_n;
            phase_q   <= phase_n;
            bus_q     <= bus_n;
            stop_q    <= stop_n;
            icnt_q    <= icnt_n;
            running_q <= is_active(state_n);
            halted_q  <= (state_n == HALTED);
        end
    end

    // Next-state and phase sequencing.
    always_comb begin
        state_n = state_q;
        phase_n = phase_q;
        bus_n   = bus_q;
        stop_n  = stop_q;
        icnt_n  = icnt_q;

        if (reset_ps_q) begin
            // Datapath still in reset: stay quiet and swallow button edges.
            state_n = IDLE;
            phase_n = P1;
            bus_n   = '0;
            stop_n  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    bus_n = '0;
                    if (exec_rise) begin
                        state_n = RUN;
                        phase_n = P1;
                        bus_n   = BUS_FIRST;
                    end else if (step_rise) begin
                        state_n = STEP;
                        phase_n = P1;
                        bus_n   = BUS_FIRST;
                    end
                end

                RUN, STEP: begin
                    if (at_boundary) begin
                        icnt_n = icnt_q + ICNT_ONE;
                        if (bus.halt) begin
                            state_n = HALTED;
                            phase_n = P1;
                            bus_n   = '0;
                            stop_n  = 1'b0;
                        end else if ((state_q == STEP) || stop_now) begin
                            state_n = IDLE;
                            phase_n = P1;
                            bus_n   = '0;
                            stop_n  = 1'b0;
                        end else begin
                            phase_n = P1;
                            bus_n   = BUS_FIRST;
                        end
                    end else begin
                        phase_n = phase_q + 3'd1;
                        bus_n   = bus_q << 1;
                        if ((state_q == RUN) && exec_rise) begin
                            stop_n = 1'b1;
                        end
                    end
                end

                HALTED: begin
                    bus_n = '0;
                end

                default: begin
                    state_n = IDLE;
                    phase_n = P1;
                    bus_n   = '0;
                    stop_n  = 1'b0;
                end
            endcase
        end
    end

    assign bus.phase       = phase_q;
    assign bus.phase_bus   = bus_q;
    assign bus.reset_ps    = reset_ps_q;
    assign bus.running     = running_q;
    assign bus.halted      = halted_q;
    assign bus.instr_count = icnt_q;

endmodule

// File: tb/tb_phase_controller.sv
// tb/tb_phase_controller.sv - randomized self-checking bench for phase_controller
module tb_phase_controller;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total  = 0;
    int   cnt_model = 0;

    always #5 clock = ~clock;

    phase_controller_if #(.NUM_PHASES(5), .ICNT_W(16)) pif ();
    phase_controller_if #(.NUM_PHASES(5), .ICNT_W(4))  sif ();

    phase_controller #(.NUM_PHASES(5), .ICNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (pif.master)
    );

    phase_controller #(.NUM_PHASES(5), .ICNT_W(4)) dut_small (
        .clock (clock),
        .reset (reset),
        .bus   (sif.master)
    );

    logic [25:0] act;
    assign act = {pif.phase, pif.phase_bus, pif.running, pif.halted, pif.instr_count};

    // Expected observable tuple: idle/halted shows phase 0 with an empty bus.
    function automatic logic [25:0] expv(int ph, bit run, bit hlt, int cnt);
        logic [4:0] b;
        b = run ? (5'b00001 << ph) : 5'b00000;
        return {3'(ph), b, run, hlt, 16'(cnt)};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(int n);
        pif.exec = 0; pif.step = 0; pif.halt = 0;
        sif.exec = 0; sif.step = 0; sif.halt = 0;
        reset = 1;
        repeat (n) tick();
        reset = 0;
        tick();
        cnt_model = 0;
    endtask

    task automatic test_reset;
        pif.exec = 0; pif.step = 0; pif.halt = 0;
        reset = 1;
        repeat (3) tick();
        total++;
        if ({pif.reset_ps, act} !== {1'b1, expv(0, 0, 0, 0)})
            $display("FAIL reset_hold got %h exp %h", {pif.reset_ps, act}, {1'b1, expv(0, 0, 0, 0)});
        else passed++;
        reset = 0;
        pif.exec = 1;
        total++;
        if (pif.reset_ps !== 1'b1)
            $display("FAIL reset_ps_after_release got %b exp 1", pif.reset_ps);
        else passed++;
        tick();
        total++;
        if ({pif.reset_ps, act} !== {1'b0, expv(0, 0, 0, 0)})
            $display("FAIL reset_ps_one_cycle got %h exp %h", {pif.reset_ps, act}, {1'b0, expv(0, 0, 0, 0)});
        else passed++;
        tick();
        total++;
        if (act !== expv(0, 0, 0, 0))
            $display("FAIL exec_held_no_rise got %h exp %h", act, expv(0, 0, 0, 0));
        else passed++;
        pif.exec = 0;
        tick();
        cnt_model = 0;
    endtask

    // Run from IDLE and raise a stop on edge s after start; stop lands on the next boundary.
    task automatic test_free_run_stop(int s);
        int c0;
        int kb;
        logic [25:0] e;
        c0 = cnt_model;
        pif.exec = 1;
        tick();
        pif.exec = 0;
        total++;
        if (act !== expv(0, 1, 0, c0))
            $display("FAIL run_start got %h exp %h", act, expv(0, 1, 0, c0));
        else passed++;
        kb = ((s + 4) / 5) * 5;
        for (int k = 1; k <= kb + 2; k++) begin
            if (k == s) pif.exec = 1;
            tick();
            pif.exec = 0;
            e = (k < kb) ? expv(k % 5, 1, 0, c0 + k / 5) : expv(0, 0, 0, c0 + kb / 5);
            total++;
            if (act !== e)
                $display("FAIL free_run s=%0d k=%0d got %h exp %h", s, k, act, e);
            else passed++;
        end
        cnt_model = c0 + kb / 5;
    endtask

    task automatic test_step;
        int c0;
        logic [25:0] e;
        c0 = cnt_model;
        pif.step = 1;
        tick();
        pif.step = 0;
        total++;
        if (act !== expv(0, 1, 0, c0))
            $display("FAIL step_start got %h exp %h", act, expv(0, 1, 0, c0));
        else passed++;
        for (int k = 1; k <= 7; k++) begin
            if (k == 3) begin pif.exec = 1; pif.step = 1; end
            tick();
            pif.exec = 0; pif.step = 0;
            e = (k < 5) ? expv(k, 1, 0, c0) : expv(0, 0, 0, c0 + 1);
            total++;
            if (act !== e)
                $display("FAIL single_step k=%0d got %h exp %h", k, act, e);
            else passed++;
        end
        cnt_model = c0 + 1;
    endtask

    task automatic test_simultaneous;
        int c0;
        logic [25:0] e;
        c0 = cnt_model;
        pif.exec = 1; pif.step = 1;
        tick();
        pif.exec = 0; pif.step = 0;
        for (int k = 1; k <= 11; k++) begin
            if (k == 8) pif.exec = 1;
            tick();
            pif.exec = 0;
            e = (k < 10) ? expv(k % 5, 1, 0, c0 + k / 5) : expv(0, 0, 0, c0 + 2);
            total++;
            if (act !== e)
                $display("FAIL exec_step_together k=%0d got %h exp %h", k, act, e);
            else passed++;
        end
        cnt_model = c0 + 2;
    endtask

    // HLT seen only at a boundary edge halts; earlier pulses do nothing.
    task automatic test_halt;
        int c0;
        int kh;
        bit halted_m;
        bit h;
        logic [25:0] e;
        c0 = cnt_model;
        halted_m = 0;
        kh = 0;
        pif.exec = 1;
        tick();
        pif.exec = 0;
        for (int k = 1; k <= 24; k++) begin
            h = (k == 3) || (k > 5 && k < 10 && $urandom_range(0, 1) == 1) || (k >= 13 && k <= 15);
            if (k > 15) begin
                h = ($urandom_range(0, 1) == 1);
                pif.exec = ($urandom_range(0, 1) == 1);
                pif.step = ($urandom_range(0, 1) == 1);
            end
            pif.halt = h;
            tick();
            if (k <= 15) begin pif.exec = 0; pif.step = 0; end
            if (!halted_m && (k % 5 == 0) && h) begin
                halted_m = 1;
                kh = k;
            end
            e = halted_m ? expv(0, 0, 1, c0 + kh / 5) : expv(k % 5, 1, 0, c0 + k / 5);
            total++;
            if (act !== e)
                $display("FAIL halt k=%0d got %h exp %h", k, act, e);
            else passed++;
        end
        pif.exec = 0; pif.step = 0; pif.halt = 0;
        do_reset(2);
        total++;
        if (act !== expv(0, 0, 0, 0))
            $display("FAIL halt_exit_reset got %h exp %h", act, expv(0, 0, 0, 0));
        else passed++;
    endtask

    task automatic test_reset_mid_op;
        pif.exec = 1;
        tick();
        pif.exec = 0;
        repeat (3) tick();
        total++;
        if (act !== expv(3, 1, 0, cnt_model))
            $display("FAIL mid_op_phase3 got %h exp %h", act, expv(3, 1, 0, cnt_model));
        else passed++;
        reset = 1;
        tick();
        total++;
        if ({pif.reset_ps, act} !== {1'b1, expv(0, 0, 0, 0)})
            $display("FAIL reset_mid_op got %h exp %h", {pif.reset_ps, act}, {1'b1, expv(0, 0, 0, 0)});
        else passed++;
        reset = 0;
        tick();
        tick();
        cnt_model = 0;
        total++;
        if ({pif.reset_ps, act} !== {1'b0, expv(0, 0, 0, 0)})
            $display("FAIL reset_mid_op_idle got %h exp %h", {pif.reset_ps, act}, {1'b0, expv(0, 0, 0, 0)});
        else passed++;
    endtask

    // Narrow-counter instance: count modulo 16 wraps after 16 instructions.
    task automatic test_wrap;
        logic [11:0] got;
        logic [11:0] e;
        int kb;
        sif.exec = 1;
        tick();
        sif.exec = 0;
        kb = 90;
        for (int k = 1; k <= kb + 1; k++) begin
            if (k == 86) sif.exec = 1;
            tick();
            sif.exec = 0;
            got = {sif.phase, sif.phase_bus, sif.instr_count};
            if (k < kb) e = {3'(k % 5), 5'b00001 << (k % 5), 4'(k / 5)};
            else        e = {3'd0, 5'b00000, 4'(kb / 5)};
            total++;
            if (got !== e)
                $display("FAIL wrap k=%0d got %h exp %h", k, got, e);
            else passed++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        pif.exec = 0; pif.step = 0; pif.halt = 0;
        sif.exec = 0; sif.step = 0; sif.halt = 0;
        test_reset();
        test_free_run_stop(22);
        test_free_run_stop(2);
        test_free_run_stop(10);
        test_free_run_stop($urandom_range(1, 40));
        test_free_run_stop($urandom_range(1, 40));
        test_step();
        test_simultaneous();
        test_halt();
        test_reset_mid_op();
        do_reset(2);
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
